// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router with header marking and packet byte count.
// Optional sticky drop/underflow flag: define ROUTER_FIFO_DROP_FLAG_EN.
module router_fifo #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic             router_clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic [6:0]       pkt_count,
    output logic             full,
`ifdef ROUTER_FIFO_DROP_FLAG_EN
    output logic             drop_err,
`endif
    output logic             empty
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_valid;
    logic [6:0]         r_pkt_count;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [WIDTH:0]     w_rd_word;
    logic [6:0]         w_hdr_len;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_wr_en = write_enb && !w_full;
    assign w_rd_en = read_enb && !w_empty;

    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
    // Header length field counts payload; +1 accounts for the parity byte.
    assign w_hdr_len = {1'b0, w_rd_word[7:2]} + 7'd1;

    always_ff @(posedge router_clock) begin
        if (resetn && !soft_reset && w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge router_clock) begin
        if (!resetn || soft_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rd_word[WIDTH-1:0];
                r_valid    <= 1'b1;
                if (w_rd_word[WIDTH]) begin
                    r_pkt_count <= w_hdr_len;
                end else if (r_pkt_count != 7'd0) begin
                    r_pkt_count <= r_pkt_count - 7'd1;
                end
            end else begin
                r_valid <= 1'b0;
                if (r_pkt_count == 7'd0) begin
                    r_data_out <= '0;
                end
            end
        end
    end

`ifdef ROUTER_FIFO_DROP_FLAG_EN
    logic r_drop_err;

    always_ff @(posedge router_clock) begin
        if (!resetn || soft_reset) begin
            r_drop_err <= 1'b0;
        end else if ((write_enb && w_full) || (read_enb && w_empty)) begin
            r_drop_err <= 1'b1;
        end
    end

    assign drop_err = r_drop_err;
`endif

    assign data_out       = r_data_out;
    assign data_out_valid = r_valid;
    assign pkt_count      = r_pkt_count;
    assign full           = w_full;
    assign empty          = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// Directed testbench for router_fifo with a queue scoreboard of stored entries.
// Checks drop_err too when ROUTER_FIFO_DROP_FLAG_EN is defined.
module tb_router_fifo;

    logic       clk;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [6:0] pkt_count;
    logic       full;
    logic       empty;
`ifdef ROUTER_FIFO_DROP_FLAG_EN
    logic       drop_err;
`endif

    router_fifo #(.ADDR_W(4), .WIDTH(8)) dut (
        .router_clock   (clk),
        .resetn         (resetn),
        .soft_reset     (soft_reset),
        .write_enb      (write_enb),
        .lfd_state      (lfd_state),
        .data_in        (data_in),
        .read_enb       (read_enb),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .pkt_count      (pkt_count),
        .full           (full),
`ifdef ROUTER_FIFO_DROP_FLAG_EN
        .drop_err       (drop_err),
`endif
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb [$];
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic [6:0] exp_pkt;
    logic       exp_drop;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(data_out_valid), 32'(exp_valid));
        chk({tag, "_dout"}, 32'(data_out), 32'(exp_dout));
        chk({tag, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
        chk({tag, "_full"}, 32'(full), 32'(sb.size() == 16));
        chk({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
`ifdef ROUTER_FIFO_DROP_FLAG_EN
        chk({tag, "_drop"}, 32'(drop_err), 32'(exp_drop));
`endif
    endtask

    task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic sr, input string tag);
        logic       fm;
        logic       em;
        logic [8:0] w;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        fm = (sb.size() == 16);
        em = (sb.size() == 0);
        @(posedge clk);
        #1;
        if (sr) begin
            sb.delete();
            exp_pkt   = '0;
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
        end else begin
            if ((we && fm) || (re && em)) exp_drop = 1'b1;
            if (re && !em) begin
                w = sb.pop_front();
                exp_dout  = w[7:0];
                exp_valid = 1'b1;
                if (w[8]) exp_pkt = {1'b0, w[7:2]} + 7'd1;
                else if (exp_pkt != 0) exp_pkt = exp_pkt - 7'd1;
            end else begin
                exp_valid = 1'b0;
                if (exp_pkt == 0) exp_dout = '0;
            end
            if (we && !fm) sb.push_back({lfd, din});
        end
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] bp_d [5];
        logic [6:0] bp_p [5];
        bp_d = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
        bp_p = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};

        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        lfd_state = 1'b0; data_in = '0; read_enb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        exp_dout = '0; exp_valid = 1'b0; exp_pkt = '0; exp_drop = 1'b0;
        check_all("reset");
        resetn = 1'b1;

        // basic packet
        step(1, 1, 8'h0D, 0, 0, "bp_w");
        step(1, 0, 8'hA1, 0, 0, "bp_w");
        step(1, 0, 8'hA2, 0, 0, "bp_w");
        step(1, 0, 8'hA3, 0, 0, "bp_w");
        step(1, 0, 8'h5F, 0, 0, "bp_w");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1, 0, "bp_r");
            chk("bp_seq_dout", 32'(data_out), 32'(bp_d[i]));
            chk("bp_seq_pkt", 32'(pkt_count), 32'(bp_p[i]));
        end
        step(0, 0, 8'h00, 0, 0, "bp_idle");
        chk("bp_zero_dout", 32'(data_out), 32'h0);
        chk("bp_end_empty", 32'(empty), 32'h1);

        // empty read
        step(0, 0, 8'h00, 1, 0, "er");
        chk("er_valid", 32'(data_out_valid), 32'h0);
        chk("er_empty", 32'(empty), 32'h1);
`ifdef ROUTER_FIFO_DROP_FLAG_EN
        chk("er_drop", 32'(drop_err), 32'h1);
`endif
        step(0, 0, 8'h00, 0, 1, "sr0");

        // full / overflow
        for (int i = 1; i <= 17; i++) begin
            step(1, 0, 8'(i), 0, 0, "fl_w");
            if (i == 16) chk("fl_full16", 32'(full), 32'h1);
        end
`ifdef ROUTER_FIFO_DROP_FLAG_EN
        chk("fl_drop", 32'(drop_err), 32'h1);
`endif
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 8'h00, 1, 0, "fl_r");
            chk("fl_seq", 32'(data_out), 32'(i));
        end
        chk("fl_empty", 32'(empty), 32'h1);
        step(0, 0, 8'h00, 0, 1, "sr1");

        // simultaneous write/read across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h40 + i), 0, 0, "sm_w");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'(8'h80 + i), 1, 0, "sm_wr");
            chk("sm_occ_full", 32'(full), 32'h0);
            chk("sm_occ_empty", 32'(empty), 32'h0);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i), 0, 0, "sm_fill");
        chk("sm_full", 32'(full), 32'h1);
        step(1, 0, 8'hEE, 1, 0, "sm_fullrw");
        chk("sm_fullrw_full", 32'(full), 32'h0);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0, "sm_drain");
        chk("sm_drain_empty", 32'(empty), 32'h1);

        // soft reset mid-packet; concurrent write/read ignored
        step(1, 1, 8'h28, 0, 0, "srp_w");
        for (int i = 1; i <= 11; i++) step(1, 0, 8'(i), 0, 0, "srp_w");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, "srp_r");
        chk("srp_pkt9", 32'(pkt_count), 32'd9);
        step(1, 0, 8'h77, 1, 1, "srp_sr");
        chk("srp_empty", 32'(empty), 32'h1);
        chk("srp_pkt0", 32'(pkt_count), 32'h0);
        chk("srp_dout0", 32'(data_out), 32'h0);
        step(1, 1, 8'h04, 0, 0, "srp_hw");
        step(0, 0, 8'h00, 1, 0, "srp_hr");
        chk("srp_hdr_pkt", 32'(pkt_count), 32'd2);
        chk("srp_hdr_dout", 32'(data_out), 32'h04);

        // hard reset mid-packet
        step(1, 1, 8'h10, 0, 0, "hr_w");
        step(1, 0, 8'h33, 0, 0, "hr_w");
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb.delete();
        exp_dout = '0; exp_valid = 1'b0; exp_pkt = '0; exp_drop = 1'b0;
        check_all("hr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router: one instance per output port, written with the byte stream produced by the register stage and drained by the destination's read interface. Stores each byte with a header marker. Tracks how many bytes of the current packet remain to be read, using the length field of the header. Honours a soft reset issued by the synchroniser when the destination fails to drain in time.

## Interface
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W entries (16)
- WIDTH, 8, data byte width; each stored entry is WIDTH+1 bits
- router_clock  input  1  clock; all logic on rising edge
- resetn  input  1  reset, synchronous, active-low
- soft_reset  input  1  synchronous flush, active-high
- write_enb  input  1  write request for data_in
- lfd_state  input  1  marks the byte written this cycle as a header
- data_in  input  WIDTH  byte from register stage
- read_enb  input  1  read request from destination
- data_out  output  WIDTH  registered read data
- data_out_valid  output  1  high the cycle data_out carries a newly read byte
- pkt_count  output  7  bytes of current packet still to read (payload + parity)
- full  output  1  no free entry
- empty  output  1  no stored entry

## Operation
- Storage: DEPTH x (WIDTH+1). Bit WIDTH is the header flag, set to lfd_state at write.
- Pointers wr_ptr, rd_ptr are ADDR_W+1 bits and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ and lower ADDR_W bits equal.
- Write accepted when write_enb && !full: mem[wr_ptr] <= {lfd_state, data_in}, then wr_ptr+1. Write while full is dropped; pointers and contents are unchanged.
- Read accepted when read_enb && !empty: data_out <= mem[rd_ptr][WIDTH-1:0], data_out_valid <= 1, then rd_ptr+1.
  - Read while empty: data_out holds, data_out_valid <= 0.
- Simultaneous write and read:
  - Each is qualified independently on the current full/empty.
  - When full, only the read proceeds.
  - When empty, only the write proceeds.
  - Otherwise both proceed and occupancy is unchanged.
- Packet counter:
  - On an accepted read of an entry with header flag = 1: pkt_count <= {1'b0, data[7:2]} + 1.
  - Else on an accepted read with pkt_count != 0: pkt_count <= pkt_count - 1.
  - Otherwise it holds.
  - The header read loads the counter and is not itself counted.
- When pkt_count is 0 and no read is accepted, data_out <= 0.
- soft_reset, same cycle priority as resetn: pointers, pkt_count, data_out and data_out_valid are cleared. Memory contents are not cleared. Any concurrent write or read that cycle is ignored.
- resetn low has priority over everything. Reset values:
  - data_out = 0, data_out_valid = 0, pkt_count = 0
  - full = 0, empty = 1
  - both pointers = 0

## Timing
- Read latency 1: read_enb sampled at edge N gives data on data_out and data_out_valid = 1 after edge N.
- full and empty are combinational from the registered pointers, so they reflect an operation the cycle after its edge.
- A byte written at edge N can be read by a read request at edge N+1. There is no same-cycle write-through.
- pkt_count updates on the same edge as the corresponding data_out.
- Reset or soft_reset applied mid-packet: the next cycle shows empty = 1, pkt_count = 0, data_out = 0. A subsequent header restarts counting normally.
- Pointer wrap: after 2*DEPTH accepted writes and reads the pointers return to 0 with no glitch on full or empty.

## Configuration
- ROUTER_FIFO_DROP_FLAG_EN defined:
  - Adds output drop_err (1 bit, reset 0).
  - drop_err is set sticky on write_enb && full (overflow) or read_enb && empty (underflow).
  - Cleared only by resetn or soft_reset.
  - It is visible the cycle after the offending edge.
- Not defined: the port and its logic are absent. Drops and ignored reads remain silent as described above.

## Test plan
- Basic packet:
  - Stimulus: reset; write header 8'h0D (length 3, lfd_state = 1), payload 8'hA1, 8'hA2, 8'hA3, parity 8'h5F; then read 5 times.
  - Response: data_out sequence 0D, A1, A2, A3, 5F, each with data_out_valid = 1. pkt_count reads 4, 3, 2, 1, 0. empty = 1 afterwards. data_out = 0 the cycle after the last read.
- Full / overflow:
  - Stimulus: write 17 bytes 8'h01..8'h11 with no reads.
  - Response: full = 1 after the 16th write. Byte 8'h11 is dropped. Reading 16 times returns 01..10. With the macro defined, drop_err = 1.
- Empty read:
  - Stimulus: read_enb with the FIFO empty.
  - Response: data_out_valid = 0, pointers unchanged, empty stays 1. With the macro defined, drop_err = 1.
- Simultaneous operations: 8 entries stored; write and read together for 20 cycles.
  - Response: occupancy stays 8, full = 0, empty = 0, data order preserved across pointer wrap.
  - Also: FIFO full with both requests asserted; the read succeeds, the write is dropped, and full = 0 next cycle.
- Soft reset mid-packet:
  - Stimulus: 3 bytes of a length-10 packet already read; assert soft_reset for 1 cycle.
  - Response: empty = 1, pkt_count = 0, data_out = 0 next cycle. A new header 8'h04 is then written and read, and pkt_count = 2.
